// File: rtl/wavelet_readout_accum.sv
// Windowed I/Q accumulator for wavelet-core feedback codes.
// Sums 16<<win_sel valid samples per window and hands each result to a single-entry output register.
module wavelet_readout_accum #(
  parameter int ACC_W = 13,
  parameter int FRM_W = 8
) (
  input  logic                    clk_master,
  input  logic                    rstb,
  input  logic                    en,
  input  logic [2:0]              win_sel,
  input  logic                    sample_valid,
  input  logic [1:0]              read_out_I,
  input  logic [1:0]              read_out_Q,
  input  logic                    out_ready,
  input  logic                    flag_clr,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] acc_I,
  output logic signed [ACC_W-1:0] acc_Q,
  output logic [FRM_W-1:0]        frame_cnt,
  output logic                    overrun,
  output logic                    bad_code
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  function automatic logic signed [ACC_W-1:0] map_code(input logic [1:0] code);
    case (code)
      2'b01:   map_code = {{(ACC_W-1){1'b0}}, 1'b1};
      2'b10:   map_code = {ACC_W{1'b1}};
      default: map_code = {ACC_W{1'b0}};
    endcase
  endfunction

  function automatic logic is_bad(input logic [1:0] code);
    is_bad = (code == 2'b11);
  endfunction

  state_t                  state_r, state_s;
  logic [2:0]              win_r, win_s, win_eff_s;
  logic [11:0]             cnt_r, cnt_s, base_cnt_s, last_s;
  logic signed [ACC_W-1:0] sum_i_r, sum_i_s, sum_q_r, sum_q_s;
  logic signed [ACC_W-1:0] base_i_s, base_q_s, add_i_s, add_q_s;
  logic [FRM_W-1:0]        frm_r, frm_s;
  logic                    take_s, done_s, load_s;
  logic                    out_valid_r, out_valid_s;
  logic signed [ACC_W-1:0] acc_i_r, acc_i_s, acc_q_r, acc_q_s;
  logic [FRM_W-1:0]        frame_r, frame_s;
  logic                    overrun_r, overrun_s, bad_r, bad_s;

  // Next-state, window datapath and output-stage logic
  always_comb begin
    // Entering from IDLE the window starts from zero using the live win_sel
    win_eff_s  = (state_r == IDLE) ? win_sel : win_r;
    base_cnt_s = (state_r == IDLE) ? 12'd0 : cnt_r;
    base_i_s   = (state_r == IDLE) ? {ACC_W{1'b0}} : sum_i_r;
    base_q_s   = (state_r == IDLE) ? {ACC_W{1'b0}} : sum_q_r;
    last_s     = (12'd16 << win_eff_s) - 12'd1;
    add_i_s    = base_i_s + map_code(read_out_I);
    add_q_s    = base_q_s + map_code(read_out_Q);
    take_s     = en & sample_valid;
    done_s     = take_s & (base_cnt_s == last_s);

    state_s = state_r;
    win_s   = win_r;
    cnt_s   = cnt_r;
    sum_i_s = sum_i_r;
    sum_q_s = sum_q_r;
    if (!en) begin
      state_s = IDLE;
      cnt_s   = 12'd0;
      sum_i_s = {ACC_W{1'b0}};
      sum_q_s = {ACC_W{1'b0}};
    end else begin
      state_s = ACCUM;
      win_s   = win_eff_s;
      if (done_s) begin
        win_s   = win_sel;
        cnt_s   = 12'd0;
        sum_i_s = {ACC_W{1'b0}};
        sum_q_s = {ACC_W{1'b0}};
      end else if (take_s) begin
        cnt_s   = base_cnt_s + 12'd1;
        sum_i_s = add_i_s;
        sum_q_s = add_q_s;
      end else begin
        cnt_s   = base_cnt_s;
        sum_i_s = base_i_s;
        sum_q_s = base_q_s;
      end
    end

    load_s  = done_s & (~out_valid_r | out_ready);
    frm_s   = done_s ? (frm_r + {{(FRM_W-1){1'b0}}, 1'b1}) : frm_r;
    acc_i_s = acc_i_r;
    acc_q_s = acc_q_r;
    frame_s = frame_r;
    if (load_s) begin
      out_valid_s = 1'b1;
      acc_i_s     = add_i_s;
      acc_q_s     = add_q_s;
      frame_s     = frm_r;
    end else if (out_valid_r & out_ready) begin
      out_valid_s = 1'b0;
    end else begin
      out_valid_s = out_valid_r;
    end

    // Set events win over a simultaneous flag_clr
    if (done_s & out_valid_r & ~out_ready) begin
      overrun_s = 1'b1;
    end else if (flag_clr) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end
    if (take_s & (is_bad(read_out_I) | is_bad(read_out_Q))) begin
      bad_s = 1'b1;
    end else if (flag_clr) begin
      bad_s = 1'b0;
    end else begin
      bad_s = bad_r;
    end
  end

  // State, window and output registers
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      state_r     <= IDLE;
      win_r       <= 3'd0;
      cnt_r       <= 12'd0;
      sum_i_r     <= {ACC_W{1'b0}};
      sum_q_r     <= {ACC_W{1'b0}};
      frm_r       <= {FRM_W{1'b0}};
      out_valid_r <= 1'b0;
      acc_i_r     <= {ACC_W{1'b0}};
      acc_q_r     <= {ACC_W{1'b0}};
      frame_r     <= {FRM_W{1'b0}};
      overrun_r   <= 1'b0;
      bad_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      win_r       <= win_s;
      cnt_r       <= cnt_s;
      sum_i_r     <= sum_i_s;
      sum_q_r     <= sum_q_s;
      frm_r       <= frm_s;
      out_valid_r <= out_valid_s;
      acc_i_r     <= acc_i_s;
      acc_q_r     <= acc_q_s;
      frame_r     <= frame_s;
      overrun_r   <= overrun_s;
      bad_r       <= bad_s;
    end
  end

  assign out_valid = out_valid_r;
  assign acc_I     = acc_i_r;
  assign acc_Q     = acc_q_r;
  assign frame_cnt = frame_r;
  assign overrun   = overrun_r;
  assign bad_code  = bad_r;

endmodule
